// File: rtl/afe_inj_scan_ctrl_if.sv
// Host/AFE-side signal bundle of the injection/ToT sequencer.
//
// master : configuration/control driver (host logic or bench); drives start, abort,
//          n_inj, inj_high, inj_low and the raw comparator level comp.
// slave  : the sequencer; drives inj_out, busy, done, res_valid and the result registers.
//
//   start      host -> seq  start a burst (ignored while busy)
//   abort      host -> seq  terminate the burst, no done pulse
//   n_inj      host -> seq  number of injections
//   inj_high   host -> seq  high phase length in cycles (0 behaves as 1)
//   inj_low    host -> seq  low phase length in cycles (0 behaves as 1)
//   comp       afe  -> seq  asynchronous comparator output
//   inj_out    seq  -> afe  registered injection pulse
//   busy       seq  -> host high whenever the sequencer is not idle
//   done       seq  -> host one-cycle pulse on normal completion
//   res_valid  seq  -> host one-cycle pulse when per-pulse results update
//   tot_last, tot_max, tot_sum, hit_count  seq -> host  burst results
interface afe_inj_scan_ctrl_if #(
  parameter int unsigned TOT_W = 8,
  parameter int unsigned N_W   = 8,
  parameter int unsigned T_W   = 16,
  parameter int unsigned SUM_W = 16
);
  logic             start;
  logic             abort;
  logic [N_W-1:0]   n_inj;
  logic [T_W-1:0]   inj_high;
  logic [T_W-1:0]   inj_low;
  logic             comp;
  logic             inj_out;
  logic             busy;
  logic             done;
  logic             res_valid;
  logic [TOT_W-1:0] tot_last;
  logic [TOT_W-1:0] tot_max;
  logic [SUM_W-1:0] tot_sum;
  logic [N_W-1:0]   hit_count;

  modport master (
    output start, abort, n_inj, inj_high, inj_low, comp,
    input  inj_out, busy, done, res_valid, tot_last, tot_max, tot_sum, hit_count
  );

  modport slave (
    input  start, abort, n_inj, inj_high, inj_low, comp,
    output inj_out, busy, done, res_valid, tot_last, tot_max, tot_sum, hit_count
  );
endinterface

// File: rtl/afe_inj_scan_ctrl.sv
// AFE injection/ToT sequencer.
//
// Generates a burst of n_inj injection pulses (inj_high cycles high, inj_low cycles low)
// on inj_out and counts, per pulse, the cycles during which the synchronized comparator
// output is high (time-over-threshold). Over the burst it accumulates the last ToT, the
// maximum ToT, the saturating ToT sum and the number of pulses with a non-zero ToT.
//
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   bus_io  control/config inputs, comparator input, pulse output, status and results
module afe_inj_scan_ctrl #(
  parameter int unsigned TOT_W = 8,
  parameter int unsigned N_W   = 8,
  parameter int unsigned T_W   = 16,
  parameter int unsigned SUM_W = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  afe_inj_scan_ctrl_if.slave bus_io
);

  localparam int unsigned SumExtW = SUM_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StHigh,
    StLow,
    StFinish
  } state_e;

  state_e state_q, state_d;

  logic comp_meta_q, comp_s_q;

  logic [N_W-1:0]     rem_q, rem_d;
  logic [T_W-1:0]     timer_q, timer_d;
  logic [T_W-1:0]     high_cfg_q, high_cfg_d;
  logic [T_W-1:0]     low_cfg_q, low_cfg_d;
  logic [TOT_W-1:0]   tot_q, tot_d;
  logic [TOT_W-1:0]   tot_last_q, tot_last_d;
  logic [TOT_W-1:0]   tot_max_q, tot_max_d;
  logic [SUM_W-1:0]   tot_sum_q, tot_sum_d;
  logic [N_W-1:0]     hit_q, hit_d;
  logic               inj_out_q, inj_out_d;
  logic               res_valid_q, res_valid_d;

  logic [T_W-1:0]     high_eff, low_eff;
  logic [TOT_W-1:0]   tot_inc;
  logic [SumExtW-1:0] sum_ext;
  logic [SUM_W-1:0]   sum_sat;
  logic               timer_exp;

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      comp_meta_q <= 1'b0;
      comp_s_q    <= 1'b0;
    end else begin
      comp_meta_q <= bus_io.comp;
      comp_s_q    <= comp_meta_q;
    end
  end

  // A zero phase length behaves as one cycle.
  assign high_eff = (bus_io.inj_high == '0) ? T_W'(1) : bus_io.inj_high;
  assign low_eff  = (bus_io.inj_low == '0) ? T_W'(1) : bus_io.inj_low;

  // ToT including the current cycle, saturating at all-ones.
  assign tot_inc = (comp_s_q && (tot_q != '1)) ? tot_q + TOT_W'(1) : tot_q;

  // One extra bit catches the carry for sum saturation.
  assign sum_ext = {1'b0, tot_sum_q} + SumExtW'(tot_inc);
  assign sum_sat = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];

  assign timer_exp = (timer_q <= T_W'(1));

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    timer_d     = timer_q;
    high_cfg_d  = high_cfg_q;
    low_cfg_d   = low_cfg_q;
    tot_d       = tot_q;
    tot_last_d  = tot_last_q;
    tot_max_d   = tot_max_q;
    tot_sum_d   = tot_sum_q;
    hit_d       = hit_q;
    res_valid_d = 1'b0;

    if (bus_io.abort && (state_q != StIdle)) begin
      // Abort wins over everything; partial accumulators are kept.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            if (bus_io.n_inj != '0) begin
              state_d = StArm;
            end else begin
              state_d    = StFinish;
              tot_last_d = '0;
              tot_max_d  = '0;
              tot_sum_d  = '0;
              hit_d      = '0;
            end
          end
        end

        StArm: begin
          // Configuration is captured here, so later input changes cannot affect the burst.
          rem_d      = bus_io.n_inj;
          high_cfg_d = high_eff;
          low_cfg_d  = low_eff;
          timer_d    = high_eff;
          tot_d      = '0;
          tot_last_d = '0;
          tot_max_d  = '0;
          tot_sum_d  = '0;
          hit_d      = '0;
          state_d    = StHigh;
        end

        StHigh: begin
          if (timer_exp) begin
            state_d     = StLow;
            timer_d     = low_cfg_q;
            res_valid_d = 1'b1;
            tot_last_d  = tot_inc;
            tot_max_d   = (tot_inc > tot_max_q) ? tot_inc : tot_max_q;
            tot_sum_d   = sum_sat;
            hit_d       = (tot_inc != '0) ? hit_q + N_W'(1) : hit_q;
            rem_d       = rem_q - N_W'(1);
            tot_d       = '0;
          end else begin
            timer_d = timer_q - T_W'(1);
            tot_d   = tot_inc;
          end
        end

        StLow: begin
          if (timer_exp) begin
            if (rem_q != '0) begin
              state_d = StHigh;
              timer_d = high_cfg_q;
            end else begin
              state_d = StFinish;
            end
          end else begin
            timer_d = timer_q - T_W'(1);
          end
        end

        StFinish: begin
          state_d = StIdle;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Registered from the next state so the pin is glitch-free and aligned with StHigh.
    inj_out_d = (state_d == StHigh);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      timer_q     <= '0;
      high_cfg_q  <= '0;
      low_cfg_q   <= '0;
      tot_q       <= '0;
      tot_last_q  <= '0;
      tot_max_q   <= '0;
      tot_sum_q   <= '0;
      hit_q       <= '0;
      inj_out_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      timer_q     <= timer_d;
      high_cfg_q  <= high_cfg_d;
      low_cfg_q   <= low_cfg_d;
      tot_q       <= tot_d;
      tot_last_q  <= tot_last_d;
      tot_max_q   <= tot_max_d;
      tot_sum_q   <= tot_sum_d;
      hit_q       <= hit_d;
      inj_out_q   <= inj_out_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus_io.inj_out   = inj_out_q;
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.done      = (state_q == StFinish);
  assign bus_io.res_valid = res_valid_q;
  assign bus_io.tot_last  = tot_last_q;
  assign bus_io.tot_max   = tot_max_q;
  assign bus_io.tot_sum   = tot_sum_q;
  assign bus_io.hit_count = hit_q;

endmodule

// File: tb/tb_afe_inj_scan_ctrl.sv
// Bench for afe_inj_scan_ctrl. A second instance with a narrow ToT sum shadows every burst
// so that sum saturation is reachable within a short run.
module tb_afe_inj_scan_ctrl;

  localparam int unsigned TotW    = 8;
  localparam int unsigned NW      = 8;
  localparam int unsigned TW      = 16;
  localparam int unsigned SumW    = 16;
  localparam int unsigned SumSatW = 10;
  localparam int TotMax    = (1 << TotW) - 1;
  localparam int SumMax    = (1 << SumW) - 1;
  localparam int SumSatMax = (1 << SumSatW) - 1;

  logic clk;
  logic rst;

  afe_inj_scan_ctrl_if #(.TOT_W(TotW), .N_W(NW), .T_W(TW), .SUM_W(SumW)) mif ();
  afe_inj_scan_ctrl_if #(.TOT_W(TotW), .N_W(NW), .T_W(TW), .SUM_W(SumSatW)) sif ();

  assign sif.start    = mif.start;
  assign sif.abort    = mif.abort;
  assign sif.n_inj    = mif.n_inj;
  assign sif.inj_high = mif.inj_high;
  assign sif.inj_low  = mif.inj_low;
  assign sif.comp     = mif.comp;

  afe_inj_scan_ctrl #(.TOT_W(TotW), .N_W(NW), .T_W(TW), .SUM_W(SumW)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (mif.slave)
  );

  afe_inj_scan_ctrl #(.TOT_W(TotW), .N_W(NW), .T_W(TW), .SUM_W(SumSatW)) dut_sat (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (sif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Expected result registers (reference model state).
  int e_last, e_max, e_sum, e_sum_s, e_hits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit inj, input bit busy, input bit done,
                         input bit rv);
    chk({tag, " inj_out"}, 32'(mif.inj_out), 32'(inj));
    chk({tag, " busy"}, 32'(mif.busy), 32'(busy));
    chk({tag, " done"}, 32'(mif.done), 32'(done));
    chk({tag, " res_valid"}, 32'(mif.res_valid), 32'(rv));
    chk({tag, " tot_last"}, 32'(mif.tot_last), e_last);
    chk({tag, " tot_max"}, 32'(mif.tot_max), e_max);
    chk({tag, " tot_sum"}, 32'(mif.tot_sum), e_sum);
    chk({tag, " hit_count"}, 32'(mif.hit_count), e_hits);
    chk({tag, " tot_sum_narrow"}, 32'(sif.tot_sum), e_sum_s);
  endtask

  // One burst, checked every cycle. Cycle 0 is the cycle after the edge sampling start.
  // mode: 0 comp low, 1 comp high, 2 comp high for len cycles at offset off of each period,
  // 3 random comp. abort_at: cycle during which abort is driven (-1 for none).
  task automatic run_burst(input string name, input int n, input int h, input int l,
                           input int mode, input int off, input int len, input int abort_at);
    int hh, ll, per, fin, last, ncyc, t, p;
    bit c[];   // c[j+1] is the comp level driven during cycle j
    int tot[];
    hh   = (h == 0) ? 1 : h;
    ll   = (l == 0) ? 1 : l;
    per  = hh + ll;
    fin  = (n == 0) ? 0 : n * per + 1;
    last = (abort_at >= 0 && abort_at < fin) ? abort_at : fin;
    ncyc = fin + 4;

    c = new[ncyc + 2];
    for (int j = -1; j <= ncyc; j++) begin
      bit v;
      v = 1'b0;
      if (j >= 0 && j <= last) begin
        case (mode)
          1: v = 1'b1;
          2: if (j >= 1 && j <= n * per) v = ((j - 1) % per >= off) && ((j - 1) % per < off + len);
          3: v = 1'($urandom % 2);
          default: v = 1'b0;
        endcase
      end
      c[j + 1] = v;
    end

    // Comparator seen by the measurement lags the pin by two cycles.
    tot = new[(n > 0) ? n : 1];
    for (int q = 0; q < n; q++) begin
      t = 0;
      for (int k = 0; k < hh; k++) t += int'(c[q * per + k]);
      tot[q] = (t > TotMax) ? TotMax : t;
    end

    @(negedge clk);
    mif.n_inj    = NW'(n);
    mif.inj_high = TW'(h);
    mif.inj_low  = TW'(l);
    mif.abort    = 1'b0;
    mif.comp     = c[0];
    mif.start    = 1'b1;

    for (int i = 0; i < ncyc; i++) begin
      bit rv, inj, pulse_cyc;
      @(negedge clk);
      if ((n == 0 && i == 0) || (n > 0 && i == 1 && last >= 1)) begin
        e_last = 0; e_max = 0; e_sum = 0; e_sum_s = 0; e_hits = 0;
      end
      pulse_cyc = (n > 0) && (i >= 1) && (i <= n * per) && (i <= last);
      rv  = pulse_cyc && ((i - 1) % per == hh);
      inj = pulse_cyc && ((i - 1) % per < hh);
      if (rv) begin
        p = (i - 1) / per;
        e_last  = tot[p];
        e_max   = (tot[p] > e_max) ? tot[p] : e_max;
        e_sum   = (e_sum + tot[p] > SumMax) ? SumMax : e_sum + tot[p];
        e_sum_s = (e_sum_s + tot[p] > SumSatMax) ? SumSatMax : e_sum_s + tot[p];
        e_hits  = e_hits + ((tot[p] != 0) ? 1 : 0);
      end
      chk_all($sformatf("%s c%0d", name, i), inj, i <= last, (i == fin) && (fin <= last), rv);

      // Start pulses while busy and config changes after capture must be ignored.
      mif.start = (i <= last) ? 1'($urandom % 2) : 1'b0;
      mif.abort = (i == abort_at);
      mif.comp  = c[i + 1];
      if (i >= 1) begin
        mif.n_inj    = NW'($urandom);
        mif.inj_high = TW'($urandom_range(0, 40));
        mif.inj_low  = TW'($urandom_range(0, 40));
      end
    end
    mif.start = 1'b0;
    mif.abort = 1'b0;
    mif.comp  = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    mif.start    = 1'b0;
    mif.abort    = 1'b0;
    mif.n_inj    = '0;
    mif.inj_high = '0;
    mif.inj_low  = '0;
    mif.comp     = 1'b0;
    e_last = 0; e_max = 0; e_sum = 0; e_sum_s = 0; e_hits = 0;

    repeat (3) @(negedge clk);
    chk_all("reset_state", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Idle burst: no hits, 3 pulses of 10/5, busy 47 cycles.
    run_burst("idle", 3, 10, 5, 0, 0, 0, -1);
    chk("idle hit_count", 32'(mif.hit_count), 0);
    chk("idle tot_sum", 32'(mif.tot_sum), 0);

    // Fixed ToT of 4 per pulse.
    run_burst("fixed", 3, 20, 10, 2, 3, 4, -1);
    chk("fixed tot_last", 32'(mif.tot_last), 4);
    chk("fixed tot_max", 32'(mif.tot_max), 4);
    chk("fixed tot_sum", 32'(mif.tot_sum), 12);
    chk("fixed hit_count", 32'(mif.hit_count), 3);

    // Per-pulse ToT saturation.
    run_burst("sat", 2, 300, 4, 1, 0, 0, -1);
    chk("sat tot_last", 32'(mif.tot_last), 255);
    chk("sat tot_max", 32'(mif.tot_max), 255);
    chk("sat tot_sum", 32'(mif.tot_sum), 510);
    chk("sat hit_count", 32'(mif.hit_count), 2);

    // Sum saturation on the narrow instance (5 x 255 > 1023).
    run_burst("sumsat", 5, 300, 2, 1, 0, 0, -1);
    chk("sumsat narrow tot_sum", 32'(sif.tot_sum), 1023);
    chk("sumsat tot_sum", 32'(mif.tot_sum), 1275);

    // Abort in the 5th high cycle of pulse 2 (cycle 25).
    run_burst("abort", 4, 10, 10, 2, 1, 2, 25);
    chk("abort hit_count", 32'(mif.hit_count), 1);
    chk("abort tot_sum", 32'(mif.tot_sum), 2);
    run_burst("after_abort", 2, 6, 3, 3, 0, 0, -1);

    // Edge configurations.
    run_burst("n0", 0, 5, 5, 1, 0, 0, -1);
    chk("n0 tot_sum", 32'(mif.tot_sum), 0);
    chk("n0 hit_count", 32'(mif.hit_count), 0);
    run_burst("h0l0", 2, 0, 0, 1, 0, 0, -1);

    // Randomized bursts, some aborted.
    for (int r = 0; r < 8; r++) begin
      int n, h, l, ab;
      n  = int'($urandom_range(0, 6));
      h  = int'($urandom_range(0, 12));
      l  = int'($urandom_range(0, 8));
      ab = -1;
      if (n > 0 && $urandom_range(0, 3) == 0)
        ab = int'($urandom_range(1, n * (((h == 0) ? 1 : h) + ((l == 0) ? 1 : l)) + 1));
      run_burst($sformatf("rnd%0d", r), n, h, l, 3, 0, 0, ab);
    end

    // Asynchronous reset in the middle of a high phase.
    @(negedge clk);
    mif.n_inj    = NW'(3);
    mif.inj_high = TW'(4);
    mif.inj_low  = TW'(4);
    mif.comp     = 1'b1;
    mif.start    = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    e_last = 0; e_max = 0; e_sum = 0; e_sum_s = 0; e_hits = 0;
    chk_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    mif.comp = 1'b0;
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    run_burst("post_reset", 2, 5, 3, 2, 1, 3, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
